// File: rtl/restador_pkg.sv
`default_nettype none
// ============================================================================
// restador_pkg : shared types and operand unpacking for restador_flotante_seq
// Revision 1.0
// ============================================================================
package restador_pkg;

  localparam int C_EXP_W  = 8;
  localparam int C_MAN_W  = 23;
  localparam int C_WORD_W = 1 + C_EXP_W + C_MAN_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALIGN     = 3'd1,
    OPERATE   = 3'd2,
    NORMALIZE = 3'd3,
    DONE      = 3'd4
  } estado_t;

  typedef struct packed {
    logic               sign;
    logic [C_EXP_W-1:0] exp;
    logic [C_MAN_W:0]   sig;
  } operando_t;

  // Zero exponent (including denormals) collapses to a zero significand.
  function automatic operando_t unpack_op(input logic [C_WORD_W-1:0] w);
    operando_t u;
    u.sign = w[C_WORD_W-1];
    u.exp  = w[C_MAN_W +: C_EXP_W];
    u.sig  = (u.exp == '0) ? '0 : {1'b1, w[C_MAN_W-1:0]};
    return u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comparador_magnitud.sv
`default_nettype none
// ============================================================================
// comparador_magnitud : orders two unpacked operands so X has |X| >= |Y|
// Revision 1.0
// ============================================================================
module comparador_magnitud
  import restador_pkg::*;
#(
  parameter int EXP_W = C_EXP_W,
  parameter int MAN_W = C_MAN_W
) (
  input  logic             i_sa,
  input  logic [EXP_W-1:0] i_ea,
  input  logic [MAN_W:0]   i_ma,
  input  logic             i_sb,
  input  logic [EXP_W-1:0] i_eb,
  input  logic [MAN_W:0]   i_mb,
  output logic             o_sx,
  output logic [EXP_W-1:0] o_ex,
  output logic [MAN_W:0]   o_mx,
  output logic             o_sy,
  output logic [MAN_W:0]   o_my,
  output logic [EXP_W-1:0] o_diff
);

  logic w_a_ge_b;

  assign w_a_ge_b = (i_ea > i_eb) || ((i_ea == i_eb) && (i_ma >= i_mb));

  always_comb begin
    o_sx   = i_sa;
    o_ex   = i_ea;
    o_mx   = i_ma;
    o_sy   = i_sb;
    o_my   = i_mb;
    o_diff = i_ea - i_eb;
    if (!w_a_ge_b) begin
      o_sx   = i_sb;
      o_ex   = i_eb;
      o_mx   = i_mb;
      o_sy   = i_sa;
      o_my   = i_ma;
      o_diff = i_eb - i_ea;
    end
  end

endmodule
`default_nettype wire

// File: rtl/restador_flotante_seq.sv
`default_nettype none
// ============================================================================
// restador_flotante_seq : multi-cycle floating-point subtractor s = a - b
// Revision 1.0
// ============================================================================
module restador_flotante_seq
  import restador_pkg::*;
#(
  parameter int EXP_W = C_EXP_W,
  parameter int MAN_W = C_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] s,
  output logic                 exp_out
);

  localparam logic [EXP_W-1:0] C_ALIGN_LIM = EXP_W'(MAN_W + 1);

  estado_t r_state;
  estado_t w_next;

  logic                 w_sa, w_sb;
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [MAN_W:0]       w_ma, w_mb;
  logic                 w_sx, w_sy;
  logic [EXP_W-1:0]     w_ex, w_diff;
  logic [MAN_W:0]       w_mx, w_my;

  logic                 r_sign_x, r_sign_y;
  logic [EXP_W-1:0]     r_exp, r_diff;
  logic [MAN_W:0]       r_mx, r_my;
  logic [MAN_W+1:0]     r_sum;
  logic [EXP_W+MAN_W:0] r_s;
  logic                 r_exp_out;

  logic [EXP_W-1:0]     w_exp_inc;
  logic                 w_carry, w_hidden;

  generate
    if (EXP_W == C_EXP_W && MAN_W == C_MAN_W) begin : g_pkg_unpack
      operando_t w_ua, w_ub;
      assign w_ua = unpack_op(a);
      assign w_ub = unpack_op(b);
      assign w_sa = w_ua.sign;
      assign w_ea = w_ua.exp;
      assign w_ma = w_ua.sig;
      assign w_sb = w_ub.sign;
      assign w_eb = w_ub.exp;
      assign w_mb = w_ub.sig;
    end else begin : g_gen_unpack
      assign w_sa = a[EXP_W+MAN_W];
      assign w_ea = a[MAN_W +: EXP_W];
      assign w_ma = (w_ea == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
      assign w_sb = b[EXP_W+MAN_W];
      assign w_eb = b[MAN_W +: EXP_W];
      assign w_mb = (w_eb == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    end
  endgenerate

  // Subtraction is addition of b with its sign flipped.
  comparador_magnitud #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_cmp (
    .i_sa   (w_sa),
    .i_ea   (w_ea),
    .i_ma   (w_ma),
    .i_sb   (~w_sb),
    .i_eb   (w_eb),
    .i_mb   (w_mb),
    .o_sx   (w_sx),
    .o_ex   (w_ex),
    .o_mx   (w_mx),
    .o_sy   (w_sy),
    .o_my   (w_my),
    .o_diff (w_diff)
  );

  assign w_exp_inc = r_exp + EXP_W'(1);
  assign w_carry   = r_sum[MAN_W+1];
  assign w_hidden  = r_sum[MAN_W];

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign exp_out   = r_exp_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (in_valid) w_next = ALIGN;
      ALIGN:     if (r_diff == '0) w_next = OPERATE;
      OPERATE:   w_next = NORMALIZE;
      NORMALIZE: begin
        if (r_sum == '0) begin
          w_next = DONE;
        end else if (w_carry) begin
          if (w_exp_inc == '1) w_next = DONE;
        end else if (w_hidden || (r_exp == EXP_W'(1))) begin
          w_next = DONE;
        end
      end
      DONE:      if (out_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_x  <= 1'b0;
      r_sign_y  <= 1'b0;
      r_exp     <= '0;
      r_diff    <= '0;
      r_mx      <= '0;
      r_my      <= '0;
      r_sum     <= '0;
      r_s       <= '0;
      r_exp_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign_x  <= w_sx;
            r_sign_y  <= w_sy;
            r_exp     <= w_ex;
            r_mx      <= w_mx;
            r_my      <= w_my;
            r_diff    <= w_diff;
            r_exp_out <= 1'b0;
          end
        end
        ALIGN: begin
          // Large gaps flush Y at once instead of shifting it out bit by bit.
          if (r_diff != '0) begin
            if (r_diff > C_ALIGN_LIM) begin
              r_my   <= '0;
              r_diff <= '0;
            end else begin
              r_my   <= r_my >> 1;
              r_diff <= r_diff - EXP_W'(1);
            end
          end
        end
        OPERATE: begin
          if (r_sign_x == r_sign_y) begin
            r_sum <= {1'b0, r_mx} + {1'b0, r_my};
          end else begin
            r_sum <= {1'b0, r_mx} - {1'b0, r_my};
          end
        end
        NORMALIZE: begin
          if (r_sum == '0) begin
            r_s <= '0;
          end else if (w_carry) begin
            r_sum <= r_sum >> 1;
            r_exp <= w_exp_inc;
            if (w_exp_inc == '1) begin
              r_exp_out <= 1'b1;
              r_s       <= {r_sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
          end else if (w_hidden) begin
            r_s <= {r_sign_x, r_exp, r_sum[MAN_W-1:0]};
          end else if (r_exp == EXP_W'(1)) begin
            r_s <= {r_sign_x, {(EXP_W+MAN_W){1'b0}}};
          end else begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/restador_flotante_seq.md
Name: restador_flotante_seq

Overview:
Multi-cycle IEEE-754-style floating-point subtractor, s = a - b, complementing the combinational sumador_flotante in the arithmetic datapath. Operands enter through a valid/ready handshake. Alignment and normalization shift one bit per clock, so area stays small. The result is held until the consumer accepts it.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (hidden bit not stored); word width = 1+EXP_W+MAN_W

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  1+EXP_W+MAN_W  minuend {sign, exp, man}
b  input  1+EXP_W+MAN_W  subtrahend {sign, exp, man}
out_valid  output  1  s/exp_out valid
out_ready  input  1  consumer accepts result
s  output  1+EXP_W+MAN_W  difference a-b
exp_out  output  1  exponent overflow; s is then signed infinity

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, exp_out=0, all internal registers 0.
- Reset mid-operation aborts the operation with no output.
- Number format:
  - exp==0 means zero; denormals are treated as zero with hidden bit 0.
  - An input exp of all ones is treated as a normal number, with no Inf/NaN semantics.
  - Rounding is truncation, with no guard, round or sticky bits.
- FSM states: IDLE, ALIGN, OPERATE, NORMALIZE, DONE.
- IDLE:
  - Accept when in_valid && in_ready at a clock edge.
  - Latch a, and b with its sign inverted.
  - Unpack each operand into a MAN_W+1 bit significand with the hidden bit.
  - Swap so that operand X has magnitude >= operand Y. Compare exponent first, then significand.
  - Set diff = eX - eY. Go to ALIGN.
- ALIGN, one decision per cycle:
  - If diff==0, go to OPERATE.
  - Else if diff > MAN_W+1, set mY=0 and diff=0.
  - Else shift mY right by 1 and decrement diff.
- OPERATE, one cycle:
  - Same signs: sum = mX + mY, using MAN_W+2 bits including the carry.
  - Different signs: sum = mX - mY; this is never negative.
  - Result sign = sign of X. Go to NORMALIZE.
- NORMALIZE, one decision per cycle:
  - sum==0: result is +0 (s=0). Go to DONE.
  - Carry bit set: shift sum right by 1 and increment exp.
    - If the new exp equals all ones, set exp_out=1 and s={sign, all-ones exp, zero man}. Go to DONE.
  - Hidden bit set and carry clear: go to DONE.
  - Otherwise, if exp==1, underflow: s = signed zero {sign, 0, 0}, exp_out=0. Go to DONE.
  - Otherwise shift sum left by 1 and decrement exp.
- DONE:
  - Drive out_valid=1 with s and exp_out stable.
  - On out_valid && out_ready, clear out_valid and go to IDLE.
  - in_ready rises in that same cycle's next state. There is no back-to-back accept in the DONE cycle.
- Latency: out_valid rises (align decisions + 1 + normalize decisions) edges after the accept edge. Worst case is about 2*MAN_W+6.
- Holding outputs: s and exp_out hold their value after the handshake until the next result is loaded. exp_out clears on the next accept.
- Input changes: a and b changing while not in IDLE have no effect.

Decomposition:
- Package restador_pkg:
  - State enum estado_t {IDLE, ALIGN, OPERATE, NORMALIZE, DONE}.
  - Default EXP_W/MAN_W constants.
  - Unpack helper function returning {sign, exp, hidden+man}.
- Sub-module comparador_magnitud: combinational magnitude compare and swap of the two unpacked operands, used in IDLE.

Test Plan:
1. a=0x41010000 (8.0625), b=0x3E400000 (0.1875) -> s=0x40FC0000 (7.875), exp_out=0, out_valid 10 edges after the accept edge (7 ALIGN, 1 OPERATE, 2 NORMALIZE).
2. a=0x3F800000 (1.0), b=0x40000000 (2.0) -> s=0xBF800000 (-1.0), exp_out=0. a=b=0x40FC0000 -> s=0x00000000.
3. a=0x41200000 (10.0), b=0x00000000 -> s=0x41200000. a=0x00000000, b=0x41200000 -> s=0xC1200000.
4. a=0x7F7FFFFF, b=0xFF7FFFFF (max - (-max)) -> s=0x7F800000, exp_out=1. The next operation 0x3F800000-0x3F000000 -> s=0x3F000000, exp_out=0.
5. Backpressure: out_ready held low for 5 cycles in DONE -> out_valid and s stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE on the next edge.
6. rst_n pulsed low asynchronously mid-ALIGN (between edges) -> out_valid=0, in_ready=1 immediately. A new subtraction after release completes correctly.
